// File: rtl/volume_adjust_if.sv
// ============================================================================
// Module : volume_adjust_if
// Brief  : PCM sample/volume bundle between the sample-table read, the volume
//          stage and the I2S serializer.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface volume_adjust_if #(
   parameter int SAMPLE_BITS = 16,
   parameter int VOLUME_BITS = 4
);
   logic signed [SAMPLE_BITS-1:0] sample_in;
   logic        [VOLUME_BITS-1:0] volume;
   logic signed [SAMPLE_BITS-1:0] sample_out;

   modport master (
      output sample_in,
      output volume,
      input  sample_out
   );

   modport slave (
      input  sample_in,
      input  volume,
      output sample_out
   );
endinterface

`default_nettype wire

// File: rtl/volume_adjust.sv
// ============================================================================
// Module : volume_adjust
// Brief  : Per-sample volume scaling, registered on mclk. Optional volume
//          ramping enabled by defining VOLUME_ADJUST_RAMP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module volume_adjust #(
   parameter int SAMPLE_BITS = 16,
   parameter int VOLUME_BITS = 4,
   parameter int RAMP_DIV    = 256
) (
   input  wire logic        mclk,
   input  wire logic        rst,
   volume_adjust_if.slave   bus
);

   localparam int PROD_BITS = SAMPLE_BITS + VOLUME_BITS + 1;

   if (SAMPLE_BITS < 2 || VOLUME_BITS < 1 || RAMP_DIV < 1) begin : g_param_check
      $error("volume_adjust: illegal parameterisation");
   end

   logic [VOLUME_BITS-1:0] veff;

`ifdef VOLUME_ADJUST_RAMP_EN
   localparam int CNT_BITS = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(RAMP_DIV - 1);

   logic [CNT_BITS-1:0]    cnt_q,  cnt_d;
   logic [VOLUME_BITS-1:0] veff_q, veff_d;

   // Retargeting only changes the step direction; the prescaler phase is kept.
   always_comb begin
      cnt_d  = cnt_q;
      veff_d = veff_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         if (veff_q < bus.volume) begin
            veff_d = veff_q + 1'b1;
         end else if (veff_q > bus.volume) begin
            veff_d = veff_q - 1'b1;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         cnt_q  <= '0;
         veff_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         veff_q <= veff_d;
      end
   end

   assign veff = veff_q;
`else
   assign veff = bus.volume;
`endif

   logic signed [PROD_BITS-1:0]   w_sample_ext;
   logic signed [PROD_BITS-1:0]   w_vol_ext;
   logic signed [PROD_BITS-1:0]   w_product;
   logic signed [PROD_BITS-1:0]   w_shifted;
   logic signed [SAMPLE_BITS-1:0] sample_out_q, sample_out_d;

   // |gain| < 1 below unity, so truncating the shifted product never overflows.
   always_comb begin
      w_sample_ext = {{(VOLUME_BITS + 1){bus.sample_in[SAMPLE_BITS-1]}}, bus.sample_in};
      w_vol_ext    = {{(SAMPLE_BITS + 1){1'b0}}, veff};
      w_product    = w_sample_ext * w_vol_ext;
      w_shifted    = w_product >>> VOLUME_BITS;
      if (veff == {VOLUME_BITS{1'b1}}) begin
         sample_out_d = bus.sample_in;
      end else if (veff == '0) begin
         sample_out_d = '0;
      end else begin
         sample_out_d = SAMPLE_BITS'(w_shifted);
      end
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         sample_out_q <= '0;
      end else begin
         sample_out_q <= sample_out_d;
      end
   end

   assign bus.sample_out = sample_out_q;

endmodule

`default_nettype wire

// File: tb/tb_volume_adjust.sv
// ============================================================================
// Module : tb_volume_adjust
// Brief  : Self-checking bench for volume_adjust against an arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_volume_adjust;

   logic mclk = 1'b0;
   logic rst  = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 mclk = ~mclk;

   volume_adjust_if #(.SAMPLE_BITS(16), .VOLUME_BITS(4)) bus ();

   volume_adjust #(
      .SAMPLE_BITS (16),
      .VOLUME_BITS (4),
      .RAMP_DIV    (4)
   ) dut (
      .mclk (mclk),
      .rst  (rst),
      .bus  (bus.slave)
   );

   // Gain rule from first principles: unity, mute, or floor(s*v/16).
   function automatic int ref_gain(input int s, input int v);
      int p;
      if (v == 15) return s;
      if (v == 0)  return 0;
      p = s * v;
      if (p >= 0) return p / 16;
      return -((-p + 15) / 16);
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int s, input int v);
      bus.sample_in = 16'(s);
      bus.volume    = 4'(v);
      @(posedge mclk);
      #1;
   endtask

   initial begin
      int s;
      int v;
      int prev_s;
      bus.sample_in = 16'sh7FFF;
      bus.volume    = 4'd15;

      // Reset holds output at zero regardless of inputs.
      rst = 1'b1;
      step(32767, 15);
      check("reset_0", bus.sample_out, 0);
      step(32767, 15);
      check("reset_1", bus.sample_out, 0);
      rst = 1'b0;

`ifdef VOLUME_ADJUST_RAMP_EN
      // Edge k after release uses veff = min(15, k/4).
      for (int k = 0; k < 70; k++) begin
         step(16000, 15);
         check("ramp_up", bus.sample_out, ref_gain(16000, (k / 4 > 15) ? 15 : k / 4));
         if (k == 32) check("ramp_v8", bus.sample_out, 8000);
      end
      check("ramp_top", bus.sample_out, 16000);
      // Prescaler phase continues: first downward step visible at edge 72.
      for (int k = 70; k < 136; k++) begin
         v = 15 - (k - 68) / 4;
         if (v < 0) v = 0;
         step(16000, 0);
         check("ramp_down", bus.sample_out, ref_gain(16000, v));
      end
      check("ramp_floor", bus.sample_out, 0);
`else
      step(32767, 15);
      check("unity_release", bus.sample_out, 32767);

      step(1000, 8);
      check("v8_pos", bus.sample_out, 500);
      step(-1000, 8);
      check("v8_neg", bus.sample_out, -500);
      step(32767, 14);
      check("v14_max", bus.sample_out, 28671);
      step(-32768, 14);
      check("v14_min", bus.sample_out, -28672);
      step(-1, 1);
      check("v1_floor", bus.sample_out, -1);
      step(15, 1);
      check("v1_small", bus.sample_out, 0);
      step(15, 1);
      check("hold", bus.sample_out, 0);

      for (int k = -32768; k <= 32767; k += 257) begin
         step(k, 0);
         check("mute_sweep", bus.sample_out, 0);
      end
      step(32767, 0);
      check("mute_top", bus.sample_out, 0);

      prev_s = 0;
      for (int k = 0; k < 40; k++) begin
         s = int'($signed(16'($urandom)));
         step(s, 15);
         check("unity_rand", bus.sample_out, s);
         if (k > 0) check("unity_not_prev", (prev_s == s) || (bus.sample_out != 16'(prev_s)), 1);
         prev_s = s;
      end

      step(12345, 15);
      check("mid_pre", bus.sample_out, 12345);
      rst = 1'b1;
      step(12345, 15);
      check("mid_rst", bus.sample_out, 0);
      rst = 1'b0;
      step(12345, 15);
      check("mid_release", bus.sample_out, 12345);

      for (int k = 0; k < 300; k++) begin
         s = int'($signed(16'($urandom)));
         v = int'($urandom_range(0, 15));
         if (k % 37 == 0) s = -32768;
         if (k % 41 == 0) s = 32767;
         step(s, v);
         check("rand", bus.sample_out, ref_gain(s, v));
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/volume_adjust.md
Name: volume_adjust

Overview:
- Per-sample digital volume stage in the I2S playback path.
- Sits between the sample-table read and the I2S serializer.
- Scales a signed 16-bit PCM sample by an unsigned volume code.
- Output is registered on mclk so the serializer sees a stable word.

Parameters:
- SAMPLE_BITS, 16, width of signed PCM sample in/out.
- VOLUME_BITS, 4, width of unsigned volume code; instantiated with 4 in the synth top.
- RAMP_DIV, 256, mclk cycles per one-LSB volume step; used only with VOLUME_ADJUST_RAMP_EN.

Ports:
- mclk, input, 1, master clock; sole clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- sample_in, input, SAMPLE_BITS, signed two's-complement PCM sample.
- volume, input, VOLUME_BITS, unsigned volume code; 0 = mute, all-ones = unity.
- sample_out, output, SAMPLE_BITS, signed scaled sample, registered.

Behaviour:
- Interface: one clock (mclk); reset is synchronous and active-high (rst).
- Reset: while rst is high at a rising mclk edge, sample_out <= 0 and the effective-volume register <= 0. No other state exists.
- Effective volume (veff):
  - Without ramp, veff = volume, sampled the same cycle.
- Gain rule, evaluated each cycle from the current sample_in and veff:
  - veff == 2^VOLUME_BITS-1: result = sample_in exactly (unity pass-through, no attenuation).
  - veff == 0: result = 0.
  - Otherwise: result = (sample_in * veff) >>> VOLUME_BITS.
  - The multiply is signed by zero-extended unsigned, with a full-width product of SAMPLE_BITS+VOLUME_BITS+1 bits.
  - The shift is arithmetic, i.e. floor toward negative infinity; no rounding.
- Width: |gain| <= 1, so result always fits SAMPLE_BITS; no saturation logic needed. Truncate the product to SAMPLE_BITS after the shift.
- Latency: exactly 1 mclk cycle. sample_out at edge N+1 reflects sample_in and veff present before edge N+1.
- Outputs hold when inputs are stable. No handshake; the consumer samples sample_out at its own (much slower) LR/BCLK rate.
- Input changes on any cycle are accepted; there is no glitch filtering.
- rst asserted mid-stream: sample_out = 0 on the next edge. Normal operation resumes on the first edge with rst low.
- No X propagation: every register is assigned under reset.

Optional Feature:
- Macro: VOLUME_ADJUST_RAMP_EN.
- Defined:
  - veff is a register, reset to 0, with a prescaler counter 0..RAMP_DIV-1 that also resets to 0.
  - When the counter wraps, veff moves one LSB toward volume (+1 if below, -1 if above, hold if equal). No other step sizes.
  - A volume change mid-ramp retargets immediately, without restarting the counter.
  - The gain rule uses the registered veff.
  - After reset, output fades in from silence.
- Undefined:
  - veff = volume combinationally; no counter logic is synthesized.
  - RAMP_DIV is ignored.

Test Plan:
- rst=1 for 2 cycles with sample_in=16'h7FFF, volume=15 -> sample_out=0. Release rst -> next edge sample_out=32767 (unity).
- volume=8, sample_in=1000 -> sample_out=500 after 1 cycle. sample_in=-1000 -> -500.
- volume=14: sample_in=32767 -> 28671; sample_in=-32768 -> -28672. volume=1, sample_in=-1 -> -1 (floor); sample_in=15 -> 0.
- volume=0, sample_in sweeping -32768..32767 -> sample_out=0 throughout. volume=15 -> sample_out equals sample_in delayed 1 cycle, bit-exact.
- Assert rst mid-stream with volume=15, sample_in=12345 -> sample_out=0 next edge; after release -> 12345.
- [VOLUME_ADJUST_RAMP_EN, RAMP_DIV=4] reset, then volume=15, sample_in=16000:
  - veff steps 0->15 at one step per 4 cycles, reaching 15 after 60 cycles.
  - sample_out at veff=8 is 8000; final value 16000.
  - Then set volume=0 -> monotonic ramp down to 0.
